gpr_commit_tracer: RTL and testbench

Shadow-register commit tracer for the NPC simulation harness. It observes every retired instruction from the core's write-back stage and keeps a shadow copy of the architectural GPR file. Each commit is queued into a small FIFO and drained over a valid/ready stream by the difftest/DPI-C consumer. It also detects `ebreak` and latches a sticky halt with the a0 exit code.

---
 rtl/gpr_commit_tracer.sv | 163 ++++++++++++++++
 tb/tb_gpr_commit_tracer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_commit_tracer.sv
// gpr_commit_tracer: shadow GPR file plus retire-event FIFO for the difftest
// consumer, with sticky ebreak halt detection and a0 exit-code capture.
module gpr_commit_tracer #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NR_GPR = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW    = $clog2(NR_GPR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [31:0]     commit_inst,
  input  logic            commit_wen,
  input  logic [AW-1:0]   commit_waddr,
  input  logic [XLEN-1:0] commit_wdata,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [31:0]     trace_inst,
  output logic            trace_wen,
  output logic [AW-1:0]   trace_waddr,
  output logic [XLEN-1:0] trace_wdata,
  output logic [31:0]     trace_seq,
  input  logic [AW-1:0]   gpr_rd_addr,
  output logic [XLEN-1:0] gpr_rd_data,
  output logic            halt,
  output logic [XLEN-1:0] halt_code
);

  localparam int unsigned AW_F     = $clog2(DEPTH);
  localparam int unsigned CW       = AW_F + 1;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam int unsigned A0_INDEX = 10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [31:0]     seq;
  } entry_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] halt_code_q;
  logic [XLEN-1:0] shadow [NR_GPR];
  entry_t          fifo_mem [DEPTH];
  logic [AW_F-1:0] wr_ptr;
  logic [AW_F-1:0] rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     seq_ctr;

  logic   acc;
  logic   pop;
  logic   is_ebreak;
  logic   gpr_write;
  entry_t push_entry;
  entry_t head;

  // Handshake terms; ready depends only on local state, never on trace_ready.
  assign commit_ready = (state == ST_RUN) && (count < CW'(DEPTH));
  assign trace_valid  = (count != '0);
  assign acc          = commit_valid && commit_ready;
  assign pop          = trace_valid && trace_ready;
  assign is_ebreak    = (commit_inst == EBREAK);
  assign gpr_write    = commit_wen && (commit_waddr != '0);

  assign halt      = (state == ST_HALTED);
  assign halt_code = halt_code_q;

  // Shadow read port; x0 is never written so it stays at its reset value of 0.
  assign gpr_rd_data = shadow[gpr_rd_addr];

  // Build the FIFO entry, squashing x0 writes to a non-writing record.
  always_comb begin
    push_entry       = '0;
    push_entry.pc    = commit_pc;
    push_entry.inst  = commit_inst;
    push_entry.wen   = gpr_write;
    push_entry.waddr = commit_waddr;
    push_entry.wdata = gpr_write ? commit_wdata : '0;
    push_entry.seq   = seq_ctr;
  end

  // Head entry fields are forced to zero while the FIFO is empty.
  always_comb begin
    head        = trace_valid ? fifo_mem[rd_ptr] : '0;
    trace_pc    = head.pc;
    trace_inst  = head.inst;
    trace_wen   = head.wen;
    trace_waddr = head.waddr;
    trace_wdata = head.wdata;
    trace_seq   = head.seq;
  end

  // Run/halt state machine with a0 capture taken before the ebreak commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      halt_code_q <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (acc && is_ebreak) begin
            state       <= ST_HALTED;
            halt_code_q <= shadow[AW'(A0_INDEX)];
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // Architectural shadow register file; ebreak and x0 writes are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NR_GPR); i++) begin
        shadow[i] <= '0;
      end
    end else if (acc && gpr_write && !is_ebreak) begin
      shadow[commit_waddr] <= commit_wdata;
    end
  end

  // FIFO storage; contents need no reset since outputs are gated by count.
  always_ff @(posedge clk) begin
    if (acc) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers, occupancy and commit sequence counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      seq_ctr <= '0;
    end else begin
      if (acc) begin
        wr_ptr  <= wr_ptr + AW_F'(1);
        seq_ctr <= seq_ctr + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW_F'(1);
      end
      case ({acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_commit_tracer.sv
// Bench for gpr_commit_tracer: negedge scoreboard/model plus directed scenarios.
module tb_gpr_commit_tracer;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NR_GPR = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AW     = 5;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic            clk;
  logic            rst;
  logic            commit_valid;
  logic            commit_ready;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_inst;
  logic            commit_wen;
  logic [AW-1:0]   commit_waddr;
  logic [XLEN-1:0] commit_wdata;
  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [31:0]     trace_inst;
  logic            trace_wen;
  logic [AW-1:0]   trace_waddr;
  logic [XLEN-1:0] trace_wdata;
  logic [31:0]     trace_seq;
  logic [AW-1:0]   gpr_rd_addr;
  logic [XLEN-1:0] gpr_rd_data;
  logic            halt;
  logic [XLEN-1:0] halt_code;

  gpr_commit_tracer #(.XLEN(XLEN), .NR_GPR(NR_GPR), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .commit_wen   (commit_wen),
    .commit_waddr (commit_waddr),
    .commit_wdata (commit_wdata),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_pc     (trace_pc),
    .trace_inst   (trace_inst),
    .trace_wen    (trace_wen),
    .trace_waddr  (trace_waddr),
    .trace_wdata  (trace_wdata),
    .trace_seq    (trace_seq),
    .gpr_rd_addr  (gpr_rd_addr),
    .gpr_rd_data  (gpr_rd_data),
    .halt         (halt),
    .halt_code    (halt_code)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [31:0] seq;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          npop    = 0;
  int          mcount  = 0;
  logic [31:0] mseq    = '0;
  logic        mhalt   = 1'b0;
  logic [63:0] mhalt_code = '0;
  logic [63:0] mshadow [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    mcount     = 0;
    mseq       = '0;
    mhalt      = 1'b0;
    mhalt_code = '0;
    for (int i = 0; i < 32; i++) mshadow[i] = '0;
  endtask

  // Reference model and scoreboard, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    logic exp_ready;
    logic acc;
    logic pop;
    if (rst) begin
      exp_ready = !mhalt && (mcount < int'(DEPTH));
      check_eq("commit_ready", 64'(commit_ready), 64'(exp_ready));
      check_eq("trace_valid", 64'(trace_valid), 64'(mcount != 0));
      check_eq("halt", 64'(halt), 64'(mhalt));
      check_eq("halt_code", halt_code, mhalt_code);
      check_eq("gpr_rd_data", gpr_rd_data, mshadow[gpr_rd_addr]);
      if (trace_valid) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'(trace_valid), 64'(0));
        end else begin
          check_eq("trace_pc", trace_pc, sb[0].pc);
          check_eq("trace_inst", 64'(trace_inst), 64'(sb[0].inst));
          check_eq("trace_wen", 64'(trace_wen), 64'(sb[0].wen));
          check_eq("trace_waddr", 64'(trace_waddr), 64'(sb[0].waddr));
          check_eq("trace_wdata", trace_wdata, sb[0].wdata);
          check_eq("trace_seq", 64'(trace_seq), 64'(sb[0].seq));
        end
      end
      acc = commit_valid && exp_ready;
      pop = (mcount != 0) && trace_ready;
      if (acc) begin
        e.pc    = commit_pc;
        e.inst  = commit_inst;
        e.wen   = commit_wen && (commit_waddr != 0);
        e.waddr = commit_waddr;
        e.wdata = e.wen ? commit_wdata : 64'd0;
        e.seq   = mseq;
        mseq    = mseq + 32'd1;
        if (commit_inst == EBREAK) begin
          mhalt      = 1'b1;
          mhalt_code = mshadow[10];
        end else if (e.wen) begin
          mshadow[commit_waddr] = commit_wdata;
        end
        sb.push_back(e);
      end
      if (pop) begin
        void'(sb.pop_front());
        npop++;
      end
      mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  // Offer one commit starting just after a rising edge; returns whether it was taken.
  task automatic send(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                      input logic [4:0] waddr, input logic [63:0] wdata,
                      input int limit, output bit ok);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_inst  = inst;
    commit_wen   = wen;
    commit_waddr = waddr;
    commit_wdata = wdata;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (commit_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    commit_valid = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit ok;
    int n0;
    rst          = 1'b0;
    commit_valid = 1'b0;
    commit_pc    = '0;
    commit_inst  = '0;
    commit_wen   = 1'b0;
    commit_waddr = '0;
    commit_wdata = '0;
    trace_ready  = 1'b0;
    gpr_rd_addr  = '0;
    clear_model();

    // Reset state
    #2;
    check_eq("rst_trace_valid", 64'(trace_valid), 64'(0));
    check_eq("rst_commit_ready", 64'(commit_ready), 64'(1));
    check_eq("rst_trace_pc", trace_pc, 64'd0);
    check_eq("rst_trace_seq", 64'(trace_seq), 64'(0));
    check_eq("rst_gpr", gpr_rd_data, 64'd0);
    check_eq("rst_halt", 64'(halt), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single commit then x0 write
    trace_ready = 1'b1;
    send(64'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 64'd5, 4, ok);
    check_eq("t1_acc", 64'(ok), 64'(1));
    check_eq("t1_valid", 64'(trace_valid), 64'(1));
    check_eq("t1_seq", 64'(trace_seq), 64'(0));
    gpr_rd_addr = 5'd1;
    #1;
    check_eq("t1_gpr1", gpr_rd_data, 64'd5);
    send(64'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 64'hDEAD, 4, ok);
    check_eq("t2_acc", 64'(ok), 64'(1));
    check_eq("t2_wen", 64'(trace_wen), 64'(0));
    check_eq("t2_wdata", trace_wdata, 64'd0);
    gpr_rd_addr = 5'd0;
    #1;
    check_eq("t2_gpr0", gpr_rd_data, 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure and full
    do_reset();
    trace_ready = 1'b0;
    n0 = npop;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(64'h8000_1000 + 64'(4 * i), 32'h0000_0013, 1'b1, 5'(i + 2),
               64'(100 + i), 40, ok);
          check_eq("bp_acc", 64'(ok), 64'(1));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check_eq("bp_full_ready", 64'(commit_ready), 64'(0));
        check_eq("bp_full_valid", 64'(trace_valid), 64'(1));
        check_eq("bp_head_seq", 64'(trace_seq), 64'(0));
        trace_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check_eq("bp_drained", 64'(npop - n0), 64'(6));

    // Streaming at one commit per cycle
    do_reset();
    trace_ready = 1'b1;
    n0 = npop;
    for (int i = 0; i < 100; i++) begin
      gpr_rd_addr = 5'($urandom_range(0, 31));
      send(64'h8000_2000 + 64'(4 * i), 32'h0000_0013, 1'b1, 5'(i % 32),
           {$urandom, $urandom}, 1, ok);
      check_eq("stream_acc", 64'(ok), 64'(1));
      check_eq("stream_valid", 64'(trace_valid), 64'(1));
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("stream_pops", 64'(npop - n0), 64'(100));

    // Halt on ebreak with a0 exit code
    do_reset();
    trace_ready = 1'b1;
    n0 = npop;
    send(64'h8000_3000, 32'h02A0_0513, 1'b1, 5'd10, 64'h2A, 4, ok);
    check_eq("halt_a0_acc", 64'(ok), 64'(1));
    send(64'h8000_3004, EBREAK, 1'b0, 5'd0, 64'd0, 4, ok);
    check_eq("halt_eb_acc", 64'(ok), 64'(1));
    check_eq("halt_set", 64'(halt), 64'(1));
    check_eq("halt_code_val", halt_code, 64'h2A);
    check_eq("halt_ready", 64'(commit_ready), 64'(0));
    send(64'h8000_3008, 32'h0000_0013, 1'b1, 5'd3, 64'd9, 5, ok);
    check_eq("halt_refused", 64'(ok), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check_eq("halt_drained", 64'(npop - n0), 64'(2));
    check_eq("halt_sticky", 64'(halt), 64'(1));

    // Asynchronous reset with entries queued
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(64'h8000_4000 + 64'(4 * i), 32'h0000_0013, 1'b1, 5'd1, 64'(7 + i), 4, ok);
      check_eq("ar_acc", 64'(ok), 64'(1));
    end
    gpr_rd_addr = 5'd1;
    #1;
    check_eq("ar_pre_gpr", gpr_rd_data, 64'd9);
    #1;
    rst = 1'b0;
    clear_model();
    #1;
    check_eq("ar_valid", 64'(trace_valid), 64'(0));
    check_eq("ar_gpr", gpr_rd_data, 64'd0);
    check_eq("ar_halt", 64'(halt), 64'(0));
    check_eq("ar_ready", 64'(commit_ready), 64'(1));
    check_eq("ar_pc", trace_pc, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    trace_ready = 1'b1;
    send(64'h8000_5000, 32'h0000_0013, 1'b1, 5'd4, 64'd44, 4, ok);
    check_eq("ar_post_acc", 64'(ok), 64'(1));
    check_eq("ar_post_seq", 64'(trace_seq), 64'(0));
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
